boson_frame_writer: RTL and testbench

//  Drains 16-bit Boson pixels from the parallel_capture output FIFO, packs pixel pairs into 32-bit dwords and streams

---
 rtl/boson_pkg.sv | 32 +++
 rtl/boson_frame_writer_pixel_packer.sv | 104 ++++++++++
 rtl/boson_frame_writer.sv | 172 +++++++++++++++++
 tb/tb_boson_frame_writer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/boson_pkg.sv
// boson_pkg
//   Shared constants and state encodings for the Boson frame writer.
//   Frame geometry of the Boson core (320x256, 16-bit pixels) sets the default
//   frame length in dwords; two pixels are packed per dword.
package boson_pkg;

   localparam int BOSON_LINE_PX    = 320;
   localparam int BOSON_FRAME_ROWS = 256;
   localparam int PX_PER_DWORD     = 2;

   localparam int FRAME_DWORDS_DEF = BOSON_LINE_PX * BOSON_FRAME_ROWS / PX_PER_DWORD;
   localparam int BURST_DWORDS_DEF = 8;
   localparam int POP_GAP_DEF      = 2;

   // issue/frame FSM in the top
   typedef enum logic [1:0] {
      WR_IDLE,
      WR_RUN,
      WR_DONE
   } wr_state_e;

   // pixel pairing FSM in the packer
   typedef enum logic [2:0] {
      PK_IDLE,
      PK_LO,
      PK_GAP_LO,
      PK_HI,
      PK_GAP_HI,
      PK_FULL
   } pk_state_e;

endpackage

// File: rtl/boson_frame_writer_pixel_packer.sv
// boson_frame_writer_pixel_packer
//   Pops two pixels from the capture FIFO and assembles them into one dword
//   {second, first}. After each pop the FIFO head is not trusted for POP_GAP
//   idle cycles (FIFO read latency), timed by a down-counter.
// Ports
//   clk, resetn      clock, async active-low reset
//   pack_go          start packing a pair (from IDLE, or together with pair_take)
//   pair_take        current pair consumed by the issue logic
//   pix_d, pix_rdy   FIFO head pixel / FIFO non-empty
//   pix_next         registered 1-cycle pop strobe
//   pair_valid       a complete pair is held in pair_data
//   pair_data        {second pixel, first pixel}
//
// state     | meaning
// PK_IDLE   | nothing to do
// PK_LO     | waiting for pix_rdy to take the first pixel
// PK_GAP_LO | FIFO settling after the first pop
// PK_HI     | waiting for pix_rdy to take the second pixel
// PK_GAP_HI | FIFO settling after the second pop
// PK_FULL   | pair complete, waiting for the issue logic to consume it
module boson_frame_writer_pixel_packer
   import boson_pkg::*;
#(
   parameter int POP_GAP = POP_GAP_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        pack_go,
   input  logic        pair_take,
   input  logic [15:0] pix_d,
   input  logic        pix_rdy,
   output logic        pix_next,
   output logic        pair_valid,
   output logic [31:0] pair_data
);

   localparam int               GAP_W    = (POP_GAP < 1) ? 1 : $clog2(POP_GAP + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POP_GAP);

   pk_state_e        state_q, state_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [31:0]      data_q, data_d;
   logic             pix_next_q, pix_next_d;

   always_comb begin
      state_d    = state_q;
      gap_cnt_d  = gap_cnt_q;
      data_d     = data_q;
      pix_next_d = 1'b0;
      case (state_q)
         PK_IDLE: begin
            if (pack_go) state_d = PK_LO;
         end
         PK_LO: begin
            if (pix_rdy) begin
               data_d[15:0] = pix_d;
               pix_next_d   = 1'b1;
               gap_cnt_d    = GAP_LOAD;
               state_d      = PK_GAP_LO;
            end
         end
         PK_GAP_LO: begin
            // the pop strobe cycle itself is spent here, then POP_GAP more
            if (gap_cnt_q == '0) state_d = PK_HI;
            else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
         end
         PK_HI: begin
            if (pix_rdy) begin
               data_d[31:16] = pix_d;
               pix_next_d    = 1'b1;
               gap_cnt_d     = GAP_LOAD;
               state_d       = PK_GAP_HI;
            end
         end
         PK_GAP_HI: begin
            if (gap_cnt_q == '0) state_d = PK_FULL;
            else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
         end
         PK_FULL: begin
            if (pair_take) state_d = pack_go ? PK_LO : PK_IDLE;
         end
         default: state_d = PK_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= PK_IDLE;
         gap_cnt_q  <= '0;
         data_q     <= '0;
         pix_next_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_cnt_q  <= gap_cnt_d;
         data_q     <= data_d;
         pix_next_q <= pix_next_d;
      end
   end

   assign pix_next   = pix_next_q;
   assign pair_valid = (state_q == PK_FULL);
   assign pair_data  = data_q;

endmodule

// File: rtl/boson_frame_writer.sv
// boson_frame_writer
//   Drains Boson pixels from the capture FIFO, packs pixel pairs into dwords
//   and streams them to hyper_xface as burst writes. The first dword of a
//   burst goes out when the xface is idle; further dwords follow on
//   hram_burst_wr_rdy. If the xface closes a burst early, the pending dword
//   is reissued as the first word of a new burst.
// Ports
//   clk, resetn               clock, async active-low reset
//   start, base_addr          frame start pulse / first dword address
//   pix_d, pix_rdy, pix_next  capture FIFO head, non-empty, pop strobe
//   hram_busy                 xface busy
//   hram_burst_wr_rdy         xface ready for the next burst dword
//   hram_wr_req               1-cycle write strobe
//   hram_addr, hram_wr_d      dword address / data of the current write
//   active, done              frame in progress / 1-cycle completion pulse
//   dword_count               dwords issued this frame (saturating)
// Build option
//   BOSON_WRITER_TESTPAT_EN adds input test_pattern; when high the written
//   data is the dword address while the FIFO is still drained normally.
//
// state   | meaning
// WR_IDLE | waiting for start
// WR_RUN  | packer filling a pair; issue when the pair is complete
// WR_DONE | last dword issued, completion pulse follows
module boson_frame_writer
   import boson_pkg::*;
#(
   parameter int BURST_DWORDS = BURST_DWORDS_DEF,
   parameter int FRAME_DWORDS = FRAME_DWORDS_DEF,
   parameter int POP_GAP      = POP_GAP_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [31:0] base_addr,
   input  logic [15:0] pix_d,
   input  logic        pix_rdy,
   output logic        pix_next,
   input  logic        hram_busy,
   input  logic        hram_burst_wr_rdy,
   output logic        hram_wr_req,
   output logic [31:0] hram_addr,
   output logic [31:0] hram_wr_d,
   output logic        active,
   output logic        done,
   output logic [15:0] dword_count
`ifdef BOSON_WRITER_TESTPAT_EN
   ,
   input  logic        test_pattern
`endif
);

   localparam logic [5:0]  BURST_LAST = 6'(BURST_DWORDS - 1);
   localparam logic [16:0] FRAME_END  = 17'(FRAME_DWORDS);

   wr_state_e   state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] count_q, count_d;
   logic [5:0]  burst_idx_q, burst_idx_d;
   logic        wr_req_q, wr_req_d;
   logic        done_q, done_d;
   logic        active_q, active_d;

   logic        pack_go;
   logic        pair_take;
   logic        pair_valid;
   logic [31:0] pair_data;
   logic        first_word;
   logic        issue;
   logic        burst_closed;
   logic        last_dword;

   boson_frame_writer_pixel_packer #(
      .POP_GAP (POP_GAP)
   ) u_packer (
      .clk        (clk),
      .resetn     (resetn),
      .pack_go    (pack_go),
      .pair_take  (pair_take),
      .pix_d      (pix_d),
      .pix_rdy    (pix_rdy),
      .pix_next   (pix_next),
      .pair_valid (pair_valid),
      .pair_data  (pair_data)
   );

   assign first_word   = (burst_idx_q == '0);
   assign issue        = (state_q == WR_RUN) && pair_valid &&
                         (first_word ? !hram_busy : (hram_busy && hram_burst_wr_rdy));
   // xface dropped busy in the middle of our burst: restart as a fresh burst
   assign burst_closed = (state_q == WR_RUN) && pair_valid && !first_word && !hram_busy;
   assign last_dword   = (({1'b0, count_q} + 17'd1) == FRAME_END);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      count_d     = count_q;
      burst_idx_d = burst_idx_q;
      wr_req_d    = 1'b0;
      done_d      = 1'b0;
      active_d    = active_q;
      pack_go     = 1'b0;
      pair_take   = 1'b0;

      // address advances after the strobe cycle so it is stable while wr_req is high
      if (wr_req_q) addr_d = addr_q + 32'd1;

      case (state_q)
         WR_IDLE: begin
            if (start) begin
               state_d     = WR_RUN;
               addr_d      = base_addr;
               count_d     = '0;
               burst_idx_d = '0;
               active_d    = 1'b1;
               pack_go     = 1'b1;
            end
         end
         WR_RUN: begin
            if (issue) begin
               wr_req_d    = 1'b1;
               pair_take   = 1'b1;
               count_d     = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
               burst_idx_d = (burst_idx_q == BURST_LAST) ? 6'd0 : burst_idx_q + 6'd1;
               if (last_dword) state_d = WR_DONE;
               else            pack_go = 1'b1;
            end else if (burst_closed) begin
               burst_idx_d = '0;
            end
         end
         WR_DONE: begin
            state_d  = WR_IDLE;
            done_d   = 1'b1;
            active_d = 1'b0;
         end
         default: state_d = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= WR_IDLE;
         addr_q      <= '0;
         count_q     <= '0;
         burst_idx_q <= '0;
         wr_req_q    <= 1'b0;
         done_q      <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         burst_idx_q <= burst_idx_d;
         wr_req_q    <= wr_req_d;
         done_q      <= done_d;
         active_q    <= active_d;
      end
   end

   assign hram_wr_req = wr_req_q;
   assign hram_addr   = addr_q;
   assign active      = active_q;
   assign done        = done_q;
   assign dword_count = count_q;

`ifdef BOSON_WRITER_TESTPAT_EN
   assign hram_wr_d = test_pattern ? addr_q : pair_data;
`else
   assign hram_wr_d = pair_data;
`endif

endmodule

// File: tb/tb_boson_frame_writer.sv
`timescale 1ns/1ps
module tb_boson_frame_writer;

   localparam int BURST = 8;
   localparam int FRAME = 16;
   localparam int GAP   = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [15:0] pix_d;
   logic        pix_rdy = 1'b1;
   logic        pix_next;
   logic        hram_busy;
   logic        hram_burst_wr_rdy;
   logic        hram_wr_req;
   logic [31:0] hram_addr;
   logic [31:0] hram_wr_d;
   logic        active;
   logic        done;
   logic [15:0] dword_count;
   logic        test_pattern = 1'b0;

   always #5 clk = ~clk;

   boson_frame_writer #(
      .BURST_DWORDS (BURST),
      .FRAME_DWORDS (FRAME),
      .POP_GAP      (GAP)
   ) dut (
      .clk               (clk),
      .resetn            (resetn),
      .start             (start),
      .base_addr         (base_addr),
      .pix_d             (pix_d),
      .pix_rdy           (pix_rdy),
      .pix_next          (pix_next),
      .hram_busy         (hram_busy),
      .hram_burst_wr_rdy (hram_burst_wr_rdy),
      .hram_wr_req       (hram_wr_req),
      .hram_addr         (hram_addr),
      .hram_wr_d         (hram_wr_d),
      .active            (active),
      .done              (done),
      .dword_count       (dword_count)
`ifdef BOSON_WRITER_TESTPAT_EN
      ,
      .test_pattern      (test_pattern)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // pixel stream: value of the k-th pixel ever popped
   function automatic logic [15:0] px(input int k);
      return 16'((k * 40503 + 4660) & 32'hFFFF);
   endfunction

   // FIFO model
   int pops = 0;
   int since_pop = 99;
   bit rnd = 1'b0;
   assign pix_d = px(pops);

   // xface model
   bit xf_busy = 1'b0;
   bit xf_closing = 1'b0;
   int xf_words = 0;
   int xf_tail = 0;
   int xf_idle = 0;
   int drop_at = 0;
   assign hram_busy         = xf_busy;
   assign hram_burst_wr_rdy = xf_busy && !xf_closing;

   // scoreboard
   logic [31:0] frame_base = '0;
   int          pop_base = 0;
   bit          tp = 1'b0;
   int          wr_n = 0;
   int          done_n = 0;
   int          burst_n = 0;

   always @(negedge clk) begin
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      if (!resetn) begin
         xf_busy    = 1'b0;
         xf_closing = 1'b0;
         xf_words   = 0;
         xf_tail    = 0;
         xf_idle    = 0;
         since_pop  = 99;
      end else begin
         if (pix_next) begin
            check("pop_while_rdy", pix_rdy, 1);
            check("pop_gap", since_pop > GAP, 1);
            pops++;
            since_pop = 0;
         end else begin
            since_pop++;
         end

         if (hram_wr_req) begin
            exp_addr = frame_base + 32'(wr_n);
            exp_data = tp ? exp_addr : {px(pop_base + 2*wr_n + 1), px(pop_base + 2*wr_n)};
            check("wr_addr", hram_addr, exp_addr);
            check("wr_data", hram_wr_d, exp_data);
            if (hram_busy) check("burst_word_rdy", hram_burst_wr_rdy, 1);
            else           burst_n++;
            wr_n++;
         end

         if (done) begin
            done_n++;
            check("active_falls_with_done", active, 0);
            check("writes_at_done", wr_n, FRAME);
            check("dword_count_at_done", dword_count, FRAME);
         end

         if (xf_closing) begin
            xf_tail--;
            if (xf_tail <= 0) begin
               xf_busy    = 1'b0;
               xf_closing = 1'b0;
            end
         end
         if (hram_wr_req) begin
            xf_idle = 0;
            if (!xf_busy) begin
               xf_busy  = 1'b1;
               xf_words = 1;
            end else begin
               xf_words++;
            end
            if (drop_at > 0 && xf_words == drop_at) begin
               drop_at    = 0;
               xf_closing = 1'b1;
               xf_tail    = 3;
            end else if (xf_words == BURST) begin
               xf_closing = 1'b1;
               xf_tail    = 20;
            end
         end else if (xf_busy && !xf_closing) begin
            xf_idle++;
            if (xf_idle > 60) begin
               xf_closing = 1'b1;
               xf_tail    = 1;
            end
         end

         pix_rdy = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
      end
   end

   task automatic start_frame(input logic [31:0] b, input bit t, input bit r, input int d);
      @(posedge clk); #1;
      rnd          = r;
      drop_at      = d;
      tp           = t;
      test_pattern = t;
      frame_base   = b;
      pop_base     = pops;
      wr_n         = 0;
      done_n       = 0;
      burst_n      = 0;
      base_addr    = b;
      start        = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      base_addr = 32'hDEAD_BEEF;
      check("active_after_start", active, 1);
      check("no_pop_first_cycle", pix_next, 0);
      @(posedge clk); #1;
      if (!r) check("start_to_pop_latency", pix_next, 1);
   endtask

   task automatic finish_frame(input bit restart, input int exp_bursts);
      bit restarted = 1'b0;
      for (int c = 0; c < 4000 && done_n == 0; c++) begin
         @(posedge clk); #1;
         if (restart && !restarted && wr_n >= 5) begin
            restarted = 1'b1;
            base_addr = frame_base + 32'h777;
            start     = 1'b1;
            @(posedge clk); #1;
            start     = 1'b0;
         end
      end
      check("frame_completed", done_n != 0, 1);
      repeat (4) @(posedge clk);
      #1;
      check("done_once", done_n, 1);
      check("write_total", wr_n, FRAME);
      check("burst_total", burst_n, exp_bursts);
      check("idle_active", active, 0);
      check("idle_done", done, 0);
   endtask

   typedef struct {
      logic [31:0] base;
      bit          tp;
      bit          rnd;
      int          drop_at;
      bit          restart;
      int          exp_bursts;
   } vec_t;

   vec_t vecs[$];

   initial begin
      vecs.push_back('{32'h0000_0800, 1'b0, 1'b0, 0, 1'b0, 2});
      vecs.push_back('{32'h0000_1000, 1'b0, 1'b0, 3, 1'b0, 3});
      vecs.push_back('{32'h0000_3000, 1'b0, 1'b1, 0, 1'b0, 2});
      vecs.push_back('{32'h0000_4000, 1'b0, 1'b0, 0, 1'b1, 2});
      vecs.push_back('{32'hFFFF_FFF8, 1'b0, 1'b0, 0, 1'b0, 2});
`ifdef BOSON_WRITER_TESTPAT_EN
      vecs.push_back('{32'h0000_0100, 1'b1, 1'b0, 0, 1'b0, 2});
`endif

      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_addr", hram_addr, 0);
      check("rst_data", hram_wr_d, 0);
      check("rst_count", dword_count, 0);
      check("rst_strobes", {hram_wr_req, pix_next, active, done}, 0);
      #2 resetn = 1'b1;
      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         start_frame(vecs[i].base, vecs[i].tp, vecs[i].rnd, vecs[i].drop_at);
         finish_frame(vecs[i].restart, vecs[i].exp_bursts);
      end

      // asynchronous reset in the middle of the second burst
      start_frame(32'h0000_5000, 1'b0, 1'b0, 0);
      for (int c = 0; c < 2000 && wr_n < 10; c++) @(posedge clk);
      check("reached_burst2", wr_n >= 10, 1);
      @(posedge clk); #3;
      resetn = 1'b0;
      #1;
      check("async_rst_addr", hram_addr, 0);
      check("async_rst_data", hram_wr_d, 0);
      check("async_rst_count", dword_count, 0);
      check("async_rst_strobes", {hram_wr_req, pix_next, active, done}, 0);
      repeat (2) @(posedge clk);
      #3 resetn = 1'b1;
      repeat (2) @(posedge clk);
      start_frame(32'h0000_6000, 1'b0, 1'b0, 0);
      finish_frame(1'b0, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
